// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Next-PC sequencer and instruction-fetch controller for the RV32
//            front end. Selects the next PC from trap, redirect, pause and
//            sequential sources, drives the imem request/grant handshake and
//            inserts FLUSH_CYCLES bubbles after every control-flow change.
// Options  : PC_MISALIGN_TRAP_EN - misaligned redirect targets divert to
//            trap_vector and raise a one-cycle misalign pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   START_ADDR   = '0,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pause,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            imem_gnt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic            issue_valid,
  output logic            flush,
  output logic            misalign
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [3:0]      c_flush_load = 4'(FLUSH_CYCLES);
  localparam logic [XLEN-1:0] c_pc_step    = XLEN'(4);
  // Clears the two byte-offset bits of a redirect target.
  localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            issue_valid_q, issue_valid_d;
`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  // Next-state / next-PC selection: trap > redirect > pause > grant.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    issue_valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d    = 1'b0;
`endif
    if (state_q == ST_BOOT) begin
      state_d = ST_FETCH;
    end else if (trap_valid) begin
      pc_d    = trap_vector;
      cnt_d   = c_flush_load;
      state_d = ST_FLUSH;
    end else if (redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        pc_d       = trap_vector;
        misalign_d = 1'b1;
      end else begin
        pc_d = redirect_target;
      end
`else
      pc_d = redirect_target & c_align_mask;
`endif
      cnt_d   = c_flush_load;
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (pause) begin
            state_d = ST_STALL;
          end else if (imem_gnt) begin
            pc_d          = pc_q + c_pc_step;
            issue_valid_d = 1'b1;
          end
        end
        ST_STALL: begin
          if (!pause) state_d = ST_FETCH;
        end
        ST_FLUSH: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Control state, PC, bubble counter and issue pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= START_ADDR;
      cnt_q         <= 4'd0;
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      issue_valid_q <= issue_valid_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned-redirect pulse register.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign imem_req    = (state_q == ST_FETCH);
  assign flush       = (state_q == ST_FLUSH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign issue_valid = issue_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Self-checking bench for fetch_ctrl. Expected outputs are pushed
//            to a queue as each cycle's stimulus is driven and popped when
//            the DUT outputs settle after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int c_fc = 2;

  logic        clk = 1'b0;
  logic        rst, pause, redirect_valid, trap_valid, imem_gnt;
  logic [31:0] redirect_target, trap_vector;
  logic        imem_req, issue_valid, flush, misalign;
  logic [31:0] imem_addr, pc;

  fetch_ctrl #(.XLEN(32), .START_ADDR(32'h0), .FLUSH_CYCLES(c_fc)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .imem_gnt(imem_gnt), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .issue_valid(issue_valid), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        flush;
    logic        iv;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: 0 BOOT, 1 FETCH, 2 STALL, 3 FLUSH.
  int          m_st;
  logic [31:0] m_pc;
  int          m_cnt;
  logic        m_iv, m_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    m_iv  = 1'b0;
    m_mis = 1'b0;
    if (rst) begin
      m_st = 0; m_pc = 32'h0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (trap_valid || redirect_valid) begin
      if (trap_valid) m_pc = trap_vector;
`ifdef PC_MISALIGN_TRAP_EN
      else if (redirect_target[1:0] != 2'b00) begin
        m_pc = trap_vector; m_mis = 1'b1;
      end else m_pc = redirect_target;
`else
      else m_pc = {redirect_target[31:2], 2'b00};
`endif
      m_cnt = c_fc;
      m_st  = 3;
    end else if (m_st == 1) begin
      if (pause) m_st = 2;
      else if (imem_gnt) begin
        m_pc = m_pc + 32'd4; m_iv = 1'b1;
      end
    end else if (m_st == 2) begin
      if (!pause) m_st = 1;
    end else begin
      if (m_cnt == 1) m_st = 1;
      m_cnt = m_cnt - 1;
    end
  endtask

  // One clock: push expectation, clock, pop and compare at the negedge.
  task automatic cyc();
    exp_t e;
    model_step();
    e.pc = m_pc; e.req = (m_st == 1); e.flush = (m_st == 3);
    e.iv = m_iv; e.mis = m_mis;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_pc", pc, e.pc);
      check_eq("sb_addr", imem_addr, e.pc);
      check_eq("sb_req", {31'd0, imem_req}, {31'd0, e.req});
      check_eq("sb_flush", {31'd0, flush}, {31'd0, e.flush});
      check_eq("sb_issue", {31'd0, issue_valid}, {31'd0, e.iv});
      check_eq("sb_misalign", {31'd0, misalign}, {31'd0, e.mis});
    end
  endtask

  task automatic idle();
    rst = 0; pause = 0; redirect_valid = 0; trap_valid = 0; imem_gnt = 0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    idle(); redirect_valid = 1; redirect_target = tgt; cyc();
    idle(); for (int i = 0; i < c_fc; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    redirect_target = 32'h0; trap_vector = 32'h0;
    @(negedge clk);

    // Reset and boot with a constant grant.
    rst = 1; imem_gnt = 1;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_iv", {31'd0, issue_valid}, 32'd0);
    rst = 0; cyc();                          // BOOT cycle
    check_eq("boot_addr0", imem_addr, 32'h0);
    check_eq("boot_req", {31'd0, imem_req}, 32'd1);
    cyc(); check_eq("boot_addr1", imem_addr, 32'h4);
    check_eq("boot_iv1", {31'd0, issue_valid}, 32'd1);
    cyc(); check_eq("boot_addr2", imem_addr, 32'h8);

    // Grant backpressure at 0x10.
    cyc(); cyc();
    check_eq("bp_start", pc, 32'h10);
    n = 0; imem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); n += int'(issue_valid);
      check_eq("bp_hold", imem_addr, 32'h10);
    end
    imem_gnt = 1; cyc(); n += int'(issue_valid);
    check_eq("bp_next", imem_addr, 32'h14);
    check_eq("bp_pulses", n, 1);

    // Redirect together with a grant at 0x40.
    redirect_to(32'h40);
    idle(); redirect_valid = 1; redirect_target = 32'h200; imem_gnt = 1; cyc();
    check_eq("rd_pc", pc, 32'h200);
    check_eq("rd_iv", {31'd0, issue_valid}, 32'd0);
    n = int'(flush);
    idle(); cyc(); n += int'(flush);
    cyc(); n += int'(flush);
    check_eq("rd_flush_len", n, 2);
    check_eq("rd_req", {31'd0, imem_req}, 32'd1);
    check_eq("rd_addr", imem_addr, 32'h200);

    // Trap beats redirect in STALL, then redirect restarts the bubbles.
    pause = 1; cyc();
    check_eq("stall_req", {31'd0, imem_req}, 32'd0);
    trap_valid = 1; trap_vector = 32'h80;
    redirect_valid = 1; redirect_target = 32'h300; cyc();
    check_eq("trap_pc", pc, 32'h80);
    check_eq("trap_flush", {31'd0, flush}, 32'd1);
    idle(); redirect_valid = 1; redirect_target = 32'h400; cyc();
    check_eq("reflush_pc", pc, 32'h400);
    n = 2;
    idle(); cyc(); n += int'(flush);
    cyc(); n += int'(flush);
    check_eq("reflush_len", n, 3);

    // PC wrap, then a two-cycle pause.
    redirect_to(32'hFFFF_FFFC);
    imem_gnt = 1; cyc();
    check_eq("wrap_pc", pc, 32'h0);
    imem_gnt = 0; pause = 1;
    cyc(); check_eq("pause_req0", {31'd0, imem_req}, 32'd0);
    cyc(); check_eq("pause_pc", pc, 32'h0);
    pause = 0; cyc();
    check_eq("resume_req", {31'd0, imem_req}, 32'd1);
    check_eq("resume_addr", imem_addr, 32'h0);

    // Misaligned redirect target.
    idle(); trap_vector = 32'h80;
    redirect_valid = 1; redirect_target = 32'h102; cyc();
`ifdef PC_MISALIGN_TRAP_EN
    check_eq("mis_pc", pc, 32'h80);
    check_eq("mis_pulse", {31'd0, misalign}, 32'd1);
    idle(); cyc();
    check_eq("mis_clear", {31'd0, misalign}, 32'd0);
`else
    check_eq("mis_pc", pc, 32'h100);
    check_eq("mis_pulse", {31'd0, misalign}, 32'd0);
    idle(); cyc();
`endif

    // Randomised traffic against the model, including occasional resets.
    for (int i = 0; i < 150; i++) begin
      rst             = ($urandom_range(0, 49) == 0);
      pause           = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_target = $urandom();
      trap_valid      = ($urandom_range(0, 15) == 0);
      trap_vector     = $urandom();
      imem_gnt        = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
